// File: rtl/cic3_row_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cic3_row_pkg
// Description : Shared constants and helper functions for the CIC3 filter row:
//               output width derivation, settle sample count and the
//               decimation-select clamp.
// Revision    : 1.0 - initial release
// ============================================================================
package cic3_row_pkg;

    // Number of output samples after a restart before the comb chain holds
    // only data from after that restart.
    localparam int SETTLE_SAMPLES = 4;

    // Width of the settle counter; must hold 0..SETTLE_SAMPLES.
    localparam int SETTLE_W = 3;

    // Output word width for a given maximum log2 decimation ratio.
    // Gain is R^3 = 2^(3*log2R), and one extra bit holds the full-scale value.
    function automatic int out_width(input int dec_log2_max);
        return 3 * dec_log2_max + 1;
    endfunction

    // Clamp a requested log2 decimation ratio into 1..max_sel.
    function automatic int clamp_sel(input int sel, input int max_sel);
        if (sel < 1) begin
            return 1;
        end
        if (sel > max_sel) begin
            return max_sel;
        end
        return sel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cic3_chan.sv
`default_nettype none
// ============================================================================
// Module      : cic3_chan
// Description : One third-order CIC decimator channel. Three integrators run
//               every cycle; the three combs and the output register update
//               only on the shared tick. Disabled or restarted channels are
//               held at all-zero state.
// Revision    : 1.0 - initial release
// ============================================================================
module cic3_chan
    import cic3_row_pkg::*;
#(
    parameter int OUT_W = out_width(8)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_bit,
    input  logic             en,
    input  logic             clr,
    input  logic             tick,
    output logic [OUT_W-1:0] out
);

    // Integrator state; wrap-around is intentional, the combs undo it.
    logic [OUT_W-1:0] r_i1;
    logic [OUT_W-1:0] r_i2;
    logic [OUT_W-1:0] r_i3;

    // Comb delay elements and registered result.
    logic [OUT_W-1:0] r_d1;
    logic [OUT_W-1:0] r_d2;
    logic [OUT_W-1:0] r_d3;
    logic [OUT_W-1:0] r_out;

    // Comb chain outputs, all derived from register values in one cycle.
    logic [OUT_W-1:0] w_c1;
    logic [OUT_W-1:0] w_c2;
    logic [OUT_W-1:0] w_c3;

    // A channel is held cleared while disabled or while the row restarts.
    logic             w_hold;

    // Comb differences and hold qualifier.
    always_comb begin
        w_hold = clr || !en;
        w_c1   = r_i3 - r_d1;
        w_c2   = w_c1 - r_d2;
        w_c3   = w_c2 - r_d3;
    end

    // Integrator cascade, running every cycle at the modulator rate.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_i1 <= '0;
            r_i2 <= '0;
            r_i3 <= '0;
        end else if (w_hold) begin
            r_i1 <= '0;
            r_i2 <= '0;
            r_i3 <= '0;
        end else begin
            r_i1 <= r_i1 + OUT_W'(in_bit);
            r_i2 <= r_i2 + r_i1;
            r_i3 <= r_i3 + r_i2;
        end
    end

    // Comb delays and output word, advancing only on the decimation tick.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_d1  <= '0;
            r_d2  <= '0;
            r_d3  <= '0;
            r_out <= '0;
        end else if (w_hold) begin
            r_d1  <= '0;
            r_d2  <= '0;
            r_d3  <= '0;
            r_out <= '0;
        end else if (tick) begin
            r_d1  <= r_i3;
            r_d2  <= w_c1;
            r_d3  <= w_c2;
            r_out <= w_c3;
        end
    end

    assign out = r_out;

endmodule
`default_nettype wire

// File: rtl/cic3_echip65_rown.sv
`default_nettype none
// ============================================================================
// Module      : cic3_echip65_rown
// Description : Row of NUM_CH third-order CIC decimators with a runtime
//               power-of-two decimation ratio, per-channel enables, an
//               output-valid strobe and a settled flag. Single clock domain;
//               the decimated rate is a clock enable (tick).
// Revision    : 1.0 - initial release
// ============================================================================
module cic3_echip65_rown
    import cic3_row_pkg::*;
#(
    parameter int NUM_CH       = 24,
    parameter int DEC_LOG2_MAX = 8,
    parameter int OUT_W        = out_width(DEC_LOG2_MAX),
    parameter int SEL_W        = $clog2(DEC_LOG2_MAX + 1)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NUM_CH-1:0]       in,
    input  logic [NUM_CH-1:0]       ch_en,
    input  logic [SEL_W-1:0]        dec_sel,
    input  logic                    sync_clr,
    output logic [NUM_CH*OUT_W-1:0] out,
    output logic                    out_valid,
    output logic                    out_settled
);

    localparam logic [SETTLE_W-1:0] c_settle_max = SETTLE_W'(SETTLE_SAMPLES);
    localparam logic [SEL_W-1:0]    c_sel_rst    = SEL_W'(1);

    // Decimation select: clamped pin value and its registered copy.
    logic [SEL_W-1:0]        w_sel_eff;
    logic [SEL_W-1:0]        r_sel_q;

    // Phase counter and its terminal value R-1.
    logic [DEC_LOG2_MAX-1:0] r_ph;
    logic [DEC_LOG2_MAX-1:0] w_ph_last;

    logic                    w_restart;
    logic                    w_tick;
    logic                    r_out_valid;
    logic [SETTLE_W-1:0]     r_settle_cnt;

    // Clamp the select, derive R-1 from the registered ratio, detect restart.
    // The phase counter follows r_sel_q; whenever the two selects differ a
    // restart is pending, so the tick from the stale ratio is never used.
    always_comb begin
        w_sel_eff = SEL_W'(clamp_sel(int'(dec_sel), DEC_LOG2_MAX));
        w_ph_last = DEC_LOG2_MAX'((32'd1 << r_sel_q) - 32'd1);
        w_restart = sync_clr || (w_sel_eff != r_sel_q);
        w_tick    = (r_ph == w_ph_last);
    end

    // Registered decimation select, compared against the pin every cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sel_q <= c_sel_rst;
        end else begin
            r_sel_q <= w_sel_eff;
        end
    end

    // Phase counter 0..R-1; restart wins over the wrap.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ph <= '0;
        end else if (w_restart || w_tick) begin
            r_ph <= '0;
        end else begin
            r_ph <= r_ph + 1'b1;
        end
    end

    // Output-valid strobe, registered alongside the channel output words.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out_valid <= 1'b0;
        end else if (w_restart) begin
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= w_tick;
        end
    end

    // Settle counter: advances on the same edge that raises out_valid, so the
    // flag is already high during the strobe that delivers the 4th sample.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_settle_cnt <= '0;
        end else if (w_restart) begin
            r_settle_cnt <= '0;
        end else if (w_tick && (r_settle_cnt != c_settle_max)) begin
            r_settle_cnt <= r_settle_cnt + 1'b1;
        end
    end

    assign out_valid   = r_out_valid;
    assign out_settled = (r_settle_cnt == c_settle_max);

    // One decimator per channel, all sharing restart and tick.
    for (genvar k = 0; k < NUM_CH; k++) begin : g_chan
        cic3_chan #(
            .OUT_W (OUT_W)
        ) u_chan (
            .clk     (clk),
            .reset_n (reset_n),
            .in_bit  (in[k]),
            .en      (ch_en[k]),
            .clr     (w_restart),
            .tick    (w_tick),
            .out     (out[k*OUT_W +: OUT_W])
        );
    end

endmodule
`default_nettype wire
